// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared widths, quarter-round index tables and FSM encoding for the ChaCha engine
package chacha_pkg;
    localparam int CHACHA_W = 32;
    localparam int NWORDS   = 16;

    localparam int ROT_1 = 16;
    localparam int ROT_2 = 12;
    localparam int ROT_3 = 8;
    localparam int ROT_4 = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_t;

    // q 0..3 are the column quarter-rounds, 4..7 the diagonal ones; result packs {d, c, b, a}.
    function automatic logic [15:0] qr_index(input logic [2:0] q);
        case (q)
            3'd0:    qr_index = {4'd12, 4'd8,  4'd4, 4'd0};
            3'd1:    qr_index = {4'd13, 4'd9,  4'd5, 4'd1};
            3'd2:    qr_index = {4'd14, 4'd10, 4'd6, 4'd2};
            3'd3:    qr_index = {4'd15, 4'd11, 4'd7, 4'd3};
            3'd4:    qr_index = {4'd15, 4'd10, 4'd5, 4'd0};
            3'd5:    qr_index = {4'd12, 4'd11, 4'd6, 4'd1};
            3'd6:    qr_index = {4'd13, 4'd8,  4'd7, 4'd2};
            default: qr_index = {4'd14, 4'd9,  4'd4, 4'd3};
        endcase
    endfunction

    function automatic bit params_legal(input int rounds, input int nqr);
        return (rounds == 8 || rounds == 12 || rounds == 20) && (nqr == 1 || nqr == 2 || nqr == 4);
    endfunction
endpackage

// File: rtl/chacha_qr.sv
// rtl/chacha_qr.sv - combinational ChaCha quarter-round on four 32-bit words
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [CHACHA_W-1:0] a,
    input  logic [CHACHA_W-1:0] b,
    input  logic [CHACHA_W-1:0] c,
    input  logic [CHACHA_W-1:0] d,
    output logic [CHACHA_W-1:0] a_new,
    output logic [CHACHA_W-1:0] b_new,
    output logic [CHACHA_W-1:0] c_new,
    output logic [CHACHA_W-1:0] d_new
);
    function automatic logic [CHACHA_W-1:0] rotl(input logic [CHACHA_W-1:0] v, input int n);
        return (v << n) | (v >> (CHACHA_W - n));
    endfunction

    logic [CHACHA_W-1:0] a1, b1, c1, d1;

    assign a1    = a + b;
    assign d1    = rotl(d ^ a1, ROT_1);
    assign c1    = c + d1;
    assign b1    = rotl(b ^ c1, ROT_2);
    assign a_new = a1 + b1;
    assign d_new = rotl(d1 ^ a_new, ROT_3);
    assign c_new = c1 + d_new;
    assign b_new = rotl(b1 ^ c_new, ROT_4);
endmodule

// File: rtl/chacha_block_engine.sv
// rtl/chacha_block_engine.sv - iterative ChaCha block function with NQR quarter-round units and feed-forward
module chacha_block_engine
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20,
    parameter int NQR    = 4
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NWORDS*CHACHA_W-1:0] in_state,
    input  logic                       in_ff_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NWORDS*CHACHA_W-1:0] out_state,
    output logic                       busy
);
    localparam int STEPS = 4 * ROUNDS / NQR;

    if (!params_legal(ROUNDS, NQR)) begin : g_param_check
        $error("chacha_block_engine: ROUNDS must be 8/12/20 and NQR 1/2/4");
    end

    fsm_state_t          state;
    logic [6:0]          step_cnt;
    logic                ff;
    logic [CHACHA_W-1:0] init_w [NWORDS];
    logic [CHACHA_W-1:0] work   [NWORDS];
    logic [CHACHA_W-1:0] next_work [NWORDS];

    logic [15:0]         idx  [NQR];
    logic [CHACHA_W-1:0] qa_i [NQR];
    logic [CHACHA_W-1:0] qb_i [NQR];
    logic [CHACHA_W-1:0] qc_i [NQR];
    logic [CHACHA_W-1:0] qd_i [NQR];
    logic [CHACHA_W-1:0] qa_o [NQR];
    logic [CHACHA_W-1:0] qb_o [NQR];
    logic [CHACHA_W-1:0] qc_o [NQR];
    logic [CHACHA_W-1:0] qd_o [NQR];

    // Unit u of step s handles quarter-round (s*NQR + u) mod 8; bit 2 selects column vs diagonal.
    always_comb begin
        for (int u = 0; u < NQR; u++) begin
            idx[u]  = qr_index(3'(step_cnt * NQR + u));
            qa_i[u] = work[idx[u][3:0]];
            qb_i[u] = work[idx[u][7:4]];
            qc_i[u] = work[idx[u][11:8]];
            qd_i[u] = work[idx[u][15:12]];
        end
    end

    for (genvar g = 0; g < NQR; g++) begin : g_qr
        chacha_qr u_qr (
            .a     (qa_i[g]),
            .b     (qb_i[g]),
            .c     (qc_i[g]),
            .d     (qd_i[g]),
            .a_new (qa_o[g]),
            .b_new (qb_o[g]),
            .c_new (qc_o[g]),
            .d_new (qd_o[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NWORDS; i++) begin
            next_work[i] = work[i];
        end
        for (int u = 0; u < NQR; u++) begin
            next_work[idx[u][3:0]]   = qa_o[u];
            next_work[idx[u][7:4]]   = qb_o[u];
            next_work[idx[u][11:8]]  = qc_o[u];
            next_work[idx[u][15:12]] = qd_o[u];
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state     <= ST_IDLE;
            step_cnt  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_state <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NWORDS; i++) begin
                            init_w[i] <= in_state[CHACHA_W*i +: CHACHA_W];
                            work[i]   <= in_state[CHACHA_W*i +: CHACHA_W];
                        end
                        ff       <= in_ff_en;
                        step_cnt <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NWORDS; i++) begin
                        work[i] <= next_work[i];
                    end
                    if (step_cnt == 7'(STEPS - 1)) begin
                        step_cnt <= '0;
                        state    <= ST_FIN;
                    end else begin
                        step_cnt <= step_cnt + 7'd1;
                    end
                end
                ST_FIN: begin
                    for (int i = 0; i < NWORDS; i++) begin
                        out_state[CHACHA_W*i +: CHACHA_W] <= ff ? work[i] + init_w[i] : work[i];
                    end
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chacha_block_engine.sv
// tb/tb_chacha_block_engine.sv - randomized self-checking bench for chacha_block_engine at NQR 1, 2 and 4
module tb_chacha_block_engine;
    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic         in_ff_en;
    logic         out_ready;
    logic [511:0] in_state;
    logic         ir  [3];
    logic         ov  [3];
    logic         bsy [3];
    logic [511:0] os  [3];

    logic [31:0] qa, qb, qc, qd, qa_n, qb_n, qc_n, qd_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    chacha_block_engine #(.ROUNDS(20), .NQR(1)) dut_nqr1 (
        .g_clk(clk), .g_resetn(resetn), .in_valid(in_valid), .in_ready(ir[0]),
        .in_state(in_state), .in_ff_en(in_ff_en), .out_valid(ov[0]), .out_ready(out_ready),
        .out_state(os[0]), .busy(bsy[0])
    );
    chacha_block_engine #(.ROUNDS(20), .NQR(2)) dut_nqr2 (
        .g_clk(clk), .g_resetn(resetn), .in_valid(in_valid), .in_ready(ir[1]),
        .in_state(in_state), .in_ff_en(in_ff_en), .out_valid(ov[1]), .out_ready(out_ready),
        .out_state(os[1]), .busy(bsy[1])
    );
    chacha_block_engine #(.ROUNDS(20), .NQR(4)) dut_nqr4 (
        .g_clk(clk), .g_resetn(resetn), .in_valid(in_valid), .in_ready(ir[2]),
        .in_state(in_state), .in_ff_en(in_ff_en), .out_valid(ov[2]), .out_ready(out_ready),
        .out_state(os[2]), .busy(bsy[2])
    );
    chacha_qr u_qr (
        .a(qa), .b(qb), .c(qc), .d(qd),
        .a_new(qa_n), .b_new(qb_n), .c_new(qc_n), .d_new(qd_n)
    );

    task automatic expect_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Textbook ChaCha20: ten double rounds (columns then diagonals), optional feed-forward.
    function automatic logic [511:0] chacha_ref(input logic [511:0] st, input logic ff);
        logic [31:0]  x [16];
        logic [511:0] r;
        int ia, ib, ic, id;
        for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
        for (int dr = 0; dr < 10; dr++) begin
            for (int h = 0; h < 2; h++) begin
                for (int j = 0; j < 4; j++) begin
                    ia = j;
                    ib = 4 + (j + h) % 4;
                    ic = 8 + (j + 2*h) % 4;
                    id = 12 + (j + 3*h) % 4;
                    x[ia] += x[ib]; x[id] = rotl32(x[id] ^ x[ia], 16);
                    x[ic] += x[id]; x[ib] = rotl32(x[ib] ^ x[ic], 12);
                    x[ia] += x[ib]; x[id] = rotl32(x[id] ^ x[ia], 8);
                    x[ic] += x[id]; x[ib] = rotl32(x[ib] ^ x[ic], 7);
                end
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = ff ? x[i] + st[32*i +: 32] : x[i];
        return r;
    endfunction

    function automatic logic [511:0] rfc_state();
        logic [31:0]  w [16];
        logic [511:0] r;
        w = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
              32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
              32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
              32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic launch(input logic [511:0] st, input logic ff);
        int guard = 0;
        while (!(ir[0] && ir[1] && ir[2]) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        expect_eq("launch_idle", ir[0] & ir[1] & ir[2], 1);
        in_state = st;
        in_ff_en = ff;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    // Called at the first sample after the accept edge (t = 0); expects out_ready high.
    task automatic wait_results(input string tag, input logic [511:0] exp, output logic [511:0] res4);
        bit got [3];
        int bc  [3];
        int c;
        res4 = '0;
        for (int k = 0; k < 3; k++) begin got[k] = 1'b0; bc[k] = 0; end
        in_valid = 1'b0;
        for (int t = 0; t <= 100; t++) begin
            for (int k = 0; k < 3; k++) begin
                c = 4 * 20 / (1 << k);
                if (!got[k]) begin
                    if (bsy[k]) bc[k]++;
                    if (ov[k]) begin
                        got[k] = 1'b1;
                        expect_eq($sformatf("%s_latency_nqr%0d", tag, 1 << k), t, c + 1);
                        expect_eq($sformatf("%s_busy_nqr%0d", tag, 1 << k), bc[k], c + 1);
                        expect_eq($sformatf("%s_result_nqr%0d", tag, 1 << k), os[k], exp);
                        if (k == 2) res4 = os[k];
                    end
                end
            end
            if (got[0] && got[1] && got[2]) break;
            in_state = rand_state();
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) expect_eq($sformatf("%s_timeout_nqr%0d", tag, 1 << k), got[k], 1);
        @(negedge clk);
    endtask

    initial begin
        logic [511:0] rfc, exp, res, st2, held;
        logic         ff2;
        int           guard;

        resetn = 1'b0; in_valid = 1'b0; in_ff_en = 1'b0; out_ready = 1'b1; in_state = '0;
        qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
        repeat (3) @(negedge clk);
        expect_eq("qr_a", qa_n, 32'hea2a92f4);
        expect_eq("qr_b", qb_n, 32'hcb1cf8ce);
        expect_eq("qr_c", qc_n, 32'h4581472e);
        expect_eq("qr_d", qd_n, 32'h5881c4bb);
        for (int k = 0; k < 3; k++) begin
            expect_eq($sformatf("rst_in_ready_%0d", k), ir[k], 1);
            expect_eq($sformatf("rst_out_valid_%0d", k), ov[k], 0);
            expect_eq($sformatf("rst_busy_%0d", k), bsy[k], 0);
            expect_eq($sformatf("rst_out_state_%0d", k), os[k], '0);
        end
        resetn = 1'b1;
        @(negedge clk);

        rfc = rfc_state();
        launch(rfc, 1'b1);
        wait_results("rfc_ff1", chacha_ref(rfc, 1'b1), res);
        expect_eq("rfc_word0", res[31:0], 32'he4e7f110);
        expect_eq("rfc_word1", res[63:32], 32'h15593bd1);

        launch('0, 1'b0);
        wait_results("zero_ff0", '0, res);
        launch('0, 1'b1);
        wait_results("zero_ff1", '0, res);

        exp = chacha_ref(rfc, 1'b1);
        for (int i = 0; i < 16; i++) exp[32*i +: 32] = exp[32*i +: 32] - rfc[32*i +: 32];
        launch(rfc, 1'b0);
        wait_results("rfc_ff0", exp, res);

        for (int n = 0; n < 4; n++) begin
            st2 = rand_state();
            ff2 = 1'($urandom_range(0, 1));
            launch(st2, ff2);
            wait_results($sformatf("rand%0d", n), chacha_ref(st2, ff2), res);
        end

        // Backpressure: consumer stalls while a second block is already offered.
        out_ready = 1'b0;
        launch(rfc, 1'b1);
        st2 = rand_state();
        ff2 = 1'($urandom_range(0, 1));
        in_state = st2;
        in_ff_en = ff2;
        guard = 0;
        while (!ov[0] && guard < 120) begin
            @(negedge clk);
            guard++;
        end
        expect_eq("bp_all_done", ov[0] & ov[1] & ov[2], 1);
        held = chacha_ref(rfc, 1'b1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            expect_eq("bp_in_ready", ir[2], 0);
            expect_eq("bp_out_valid", ov[2], 1);
            expect_eq("bp_out_state", os[2], held);
        end
        out_ready = 1'b1;
        @(negedge clk);
        expect_eq("bp_release_valid", ov[2], 0);
        expect_eq("bp_release_ready", ir[2], 1);
        expect_eq("bp_state_kept", os[2], held);
        @(negedge clk);
        expect_eq("bp_next_busy", bsy[2], 1);
        expect_eq("bp_next_ready", ir[2], 0);
        wait_results("bp_second", chacha_ref(st2, ff2), res);

        // Reset in the middle of RUN discards the block.
        launch(rfc, 1'b1);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_eq($sformatf("midrst_out_valid_%0d", k), ov[k], 0);
            expect_eq($sformatf("midrst_busy_%0d", k), bsy[k], 0);
            expect_eq($sformatf("midrst_in_ready_%0d", k), ir[k], 1);
            expect_eq($sformatf("midrst_out_state_%0d", k), os[k], '0);
        end
        @(negedge clk);
        launch(rfc, 1'b1);
        wait_results("post_rst", chacha_ref(rfc, 1'b1), res);
        expect_eq("post_rst_word0", res[31:0], 32'he4e7f110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
